rgb_to_gray: RTL and testbench

Point-operation stage converting packed RGB pixels to luminance, placed directly upstream of the threshold (binarization) stage. Its `out_ready`/`out_data` pair connects straight to the threshold block's `in_enable`/`in_data`. It supports the same two work modes as the rest of the point-operation library: a streaming pipeline and a single-pixel request/acknowledge handshake. The luminance uses fixed 8-bit-fraction weights: Y = (77·R + 150·G + 29·B) >> 8.

---
 rtl/rgb_to_gray.sv | 159 +++++++++++++++
 tb/tb_rgb_to_gray.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/rgb_to_gray.sv
// rgb_to_gray: packed {R,G,B} to luminance Y = (77R + 150G + 29B) >> 8.
// Define RGB_TO_GRAY_ROUND_EN for round-half-up instead of truncation.
module rgb_to_gray #(
    parameter int work_mode   = 0,
    parameter int color_width = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_enable,
    input  logic [3*color_width-1:0] in_data,
    output logic                     out_ready,
    output logic [color_width-1:0]   out_data
);

    localparam int PW = color_width + 8;
    localparam int SW = color_width + 10;

    localparam logic [PW-1:0] W_R = PW'(77);
    localparam logic [PW-1:0] W_G = PW'(150);
    localparam logic [PW-1:0] W_B = PW'(29);

`ifdef RGB_TO_GRAY_ROUND_EN
    localparam logic [SW-1:0] RND = SW'(128);
`endif

    logic [color_width-1:0] ch_r;
    logic [color_width-1:0] ch_g;
    logic [color_width-1:0] ch_b;

    logic [PW-1:0] pr;
    logic [PW-1:0] pg;
    logic [PW-1:0] pb;

    logic [SW-1:0]          sum;
    logic [SW-1:0]          sum_nx;
    logic [color_width-1:0] y_nx;

    logic ld1;
    logic ld2;
    logic ld3;
    logic rdy;

    assign ch_r = in_data[3*color_width-1:2*color_width];
    assign ch_g = in_data[2*color_width-1:color_width];
    assign ch_b = in_data[color_width-1:0];

`ifdef RGB_TO_GRAY_ROUND_EN
    assign sum_nx = SW'(pr) + SW'(pg) + SW'(pb) + RND;
`else
    assign sum_nx = SW'(pr) + SW'(pg) + SW'(pb);
`endif

    // Saturate if anything lands above the integer part of Y.
    assign y_nx = (|sum[SW-1:PW]) ? '1 : sum[PW-1:8];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pr <= '0;
            pg <= '0;
            pb <= '0;
        end else if (ld1) begin
            pr <= PW'(ch_r) * W_R;
            pg <= PW'(ch_g) * W_G;
            pb <= PW'(ch_b) * W_B;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sum <= '0;
        end else if (ld2) begin
            sum <= sum_nx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_data <= '0;
        end else if (ld3) begin
            out_data <= y_nx;
        end
    end

    generate
        if (work_mode == 0) begin : g_pipe
            logic v1;
            logic v2;
            logic v3;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    v1 <= 1'b0;
                    v2 <= 1'b0;
                    v3 <= 1'b0;
                end else begin
                    v1 <= in_enable;
                    v2 <= v1;
                    v3 <= v2;
                end
            end

            assign ld1 = 1'b1;
            assign ld2 = 1'b1;
            assign ld3 = 1'b1;
            assign rdy = v3;
        end else begin : g_reqack
            typedef enum logic [1:0] {
                IDLE  = 2'd0,
                CALC1 = 2'd1,
                CALC2 = 2'd2,
                DONE  = 2'd3
            } state_t;

            state_t state;
            state_t state_nx;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    state <= IDLE;
                end else begin
                    state <= state_nx;
                end
            end

            always_comb begin
                state_nx = state;
                ld1      = 1'b0;
                ld2      = 1'b0;
                ld3      = 1'b0;
                unique case (state)
                    IDLE: begin
                        if (in_enable) begin
                            ld1      = 1'b1;
                            state_nx = CALC1;
                        end
                    end
                    CALC1: begin
                        ld2      = 1'b1;
                        state_nx = CALC2;
                    end
                    CALC2: begin
                        ld3      = 1'b1;
                        state_nx = DONE;
                    end
                    DONE: begin
                        if (!in_enable) begin
                            state_nx = IDLE;
                        end
                    end
                endcase
            end

            assign rdy = (state == DONE);
        end
    endgenerate

    assign out_ready = rdy;

endmodule

// File: tb/tb_rgb_to_gray.sv
// Directed bench for rgb_to_gray: pipeline and req-ack instances side by side,
// with a threshold (Y >= 128) golden model for the chained checks.
module tb_rgb_to_gray;

    logic        clk = 1'b0;
    logic        rst = 1'b0;

    logic        p_en = 1'b0;
    logic [23:0] p_dat = '0;
    logic        p_rdy;
    logic [7:0]  p_out;

    logic        r_en = 1'b0;
    logic [23:0] r_dat = '0;
    logic        r_rdy;
    logic [7:0]  r_out;

    int n_chk  = 0;
    int n_fail = 0;

    logic        pen [32];
    logic [23:0] ppx [32];
    int          pexp[32];

`ifdef RGB_TO_GRAY_ROUND_EN
    localparam int E_RED = 77;
    localparam int E_GRN = 149;
    localparam int E_BLU = 29;
    localparam int E_MIX = 91;
`else
    localparam int E_RED = 76;
    localparam int E_GRN = 149;
    localparam int E_BLU = 28;
    localparam int E_MIX = 90;
`endif

    rgb_to_gray #(.work_mode(0), .color_width(8)) dut_p (
        .clk       (clk),
        .rst       (rst),
        .in_enable (p_en),
        .in_data   (p_dat),
        .out_ready (p_rdy),
        .out_data  (p_out)
    );

    rgb_to_gray #(.work_mode(1), .color_width(8)) dut_r (
        .clk       (clk),
        .rst       (rst),
        .in_enable (r_en),
        .in_data   (r_dat),
        .out_ready (r_rdy),
        .out_data  (r_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic setp(input int i, input logic e, input logic [7:0] r,
                        input logic [7:0] g, input logic [7:0] b,
                        input int ex);
        pen[i]  = e;
        ppx[i]  = {r, g, b};
        pexp[i] = ex;
    endtask

    // Drive n table entries on consecutive cycles; output lags by 3 edges.
    task automatic pipe_run(input string tag, input int n, input bit thr);
        for (int c = 0; c < n + 3; c++) begin
            @(negedge clk);
            if (c >= 3) begin
                chk({tag, "_rdy"}, 32'(p_rdy), 32'(pen[c-3]));
                if (pen[c-3]) begin
                    chk({tag, "_dat"}, 32'(p_out), 32'(pexp[c-3]));
                    if (thr)
                        chk({tag, "_bin"}, 32'(p_out >= 8'd128),
                            32'(pexp[c-3] >= 128));
                end
            end else begin
                chk({tag, "_rdy0"}, 32'(p_rdy), 32'd0);
            end
            if (c < n) begin
                p_en  = pen[c];
                p_dat = ppx[c];
            end else begin
                p_en = 1'b0;
            end
        end
    endtask

    task automatic rstep(input string tag, input logic er, input int ed);
        @(negedge clk);
        chk({tag, "_rdy"}, 32'(r_rdy), 32'(er));
        if (er) chk({tag, "_dat"}, 32'(r_out), 32'(ed));
    endtask

    // One-cycle request pulse; DONE lasts a single cycle.
    task automatic r_pulse(input string tag, input logic [23:0] px,
                           input int ex);
        r_en  = 1'b1;
        r_dat = px;
        rstep(tag, 1'b0, 0);
        r_en  = 1'b0;
        r_dat = '0;
        rstep(tag, 1'b0, 0);
        rstep(tag, 1'b1, ex);
        chk({tag, "_bin"}, 32'(r_out >= 8'd128), 32'(ex >= 128));
        rstep(tag, 1'b0, 0);
    endtask

    initial begin
        #1 rst = 1'b1;
        #2;
        chk("rst_p_rdy", 32'(p_rdy), 32'd0);
        chk("rst_p_dat", 32'(p_out), 32'd0);
        chk("rst_r_rdy", 32'(r_rdy), 32'd0);
        chk("rst_r_dat", 32'(r_out), 32'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // Pipeline back-to-back primaries, white and black.
        setp(0, 1'b1, 8'd255, 8'd0,   8'd0,   E_RED);
        setp(1, 1'b1, 8'd0,   8'd255, 8'd0,   E_GRN);
        setp(2, 1'b1, 8'd0,   8'd0,   8'd255, E_BLU);
        setp(3, 1'b1, 8'd255, 8'd255, 8'd255, 255);
        setp(4, 1'b1, 8'd0,   8'd0,   8'd0,   0);
        pipe_run("b2b", 5, 1'b0);

        // Pipeline with enable gaps.
        setp(0, 1'b1, 8'd100, 8'd100, 8'd100, 100);
        setp(1, 1'b0, 8'd100, 8'd100, 8'd100, 100);
        setp(2, 1'b1, 8'd100, 8'd100, 8'd100, 100);
        setp(3, 1'b1, 8'd100, 8'd100, 8'd100, 100);
        setp(4, 1'b0, 8'd100, 8'd100, 8'd100, 100);
        pipe_run("gap", 5, 1'b0);

        // Pipeline chained with threshold over a gray ramp.
        setp(0, 1'b1, 8'd0,   8'd0,   8'd0,   0);
        setp(1, 1'b1, 8'd60,  8'd60,  8'd60,  60);
        setp(2, 1'b1, 8'd127, 8'd127, 8'd127, 127);
        setp(3, 1'b1, 8'd128, 8'd128, 8'd128, 128);
        setp(4, 1'b1, 8'd129, 8'd129, 8'd129, 129);
        setp(5, 1'b1, 8'd200, 8'd200, 8'd200, 200);
        setp(6, 1'b1, 8'd255, 8'd255, 8'd255, 255);
        pipe_run("ramp_p", 7, 1'b1);

        // Req-ack single pixel held, input changed after capture.
        r_en  = 1'b1;
        r_dat = {8'd200, 8'd50, 8'd10};
        rstep("ra1", 1'b0, 0);
        r_dat = 24'h0;
        rstep("ra1", 1'b0, 0);
        rstep("ra1", 1'b1, E_MIX);
        for (int k = 0; k < 4; k++) begin
            r_dat = 24'hFFFFFF;
            rstep("ra1_hold", 1'b1, E_MIX);
        end
        r_en = 1'b0;
        rstep("ra1_drop", 1'b0, 0);
        rstep("ra1_idle", 1'b0, 0);

        // Early release, then a fresh request right after.
        r_pulse("rel1", {8'd255, 8'd255, 8'd255}, 255);
        r_pulse("rel2", {8'd0, 8'd255, 8'd0}, E_GRN);

        // Req-ack chained with threshold.
        r_pulse("ramp_r0", {8'd127, 8'd127, 8'd127}, 127);
        r_pulse("ramp_r1", {8'd128, 8'd128, 8'd128}, 128);
        r_pulse("ramp_r2", {8'd40, 8'd40, 8'd40}, 40);

        // Fill both, then reset asynchronously between edges.
        p_en  = 1'b1;
        p_dat = {8'd100, 8'd100, 8'd100};
        repeat (4) @(negedge clk);
        chk("pre_rst_p_rdy", 32'(p_rdy), 32'd1);
        chk("pre_rst_p_dat", 32'(p_out), 32'd100);
        p_en  = 1'b0;
        r_en  = 1'b1;
        r_dat = {8'd255, 8'd255, 8'd255};
        @(negedge clk);
        r_en = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_p_rdy", 32'(p_rdy), 32'd0);
        chk("mid_rst_p_dat", 32'(p_out), 32'd0);
        chk("mid_rst_r_rdy", 32'(r_rdy), 32'd0);
        chk("mid_rst_r_dat", 32'(r_out), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_p_rdy", 32'(p_rdy), 32'd0);
            chk("post_rst_r_rdy", 32'(r_rdy), 32'd0);
        end

        // FSM must be idle: a new request completes on schedule.
        r_pulse("post_rst_req", {8'd100, 8'd100, 8'd100}, 100);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
